// File: rtl/ecc_148_err_collect.sv
// Registered consumer stage behind the 148-bit ECC fault detector: one-entry
// valid/ready pipe, saturating error counters, first-error log and level irq.
module ecc_148_err_collect #(
  parameter int DATA_WIDTH = 148,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sbit_err,
  input  logic                  in_dbit_err,
  input  logic                  in_ecc_fault,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_bad,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic [CNT_WIDTH-1:0]  fault_cnt,
  input  logic                  cnt_clr,
  output logic                  err_vld,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [2:0]            err_type,
  input  logic                  err_clr,
  input  logic                  irq_en,
  output logic                  irq
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                  accept;
  logic                  err_beat;
  logic [2:0]            flags;

  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  bad_q, bad_d;
  logic [CNT_WIDTH-1:0]  sbit_q, sbit_d;
  logic [CNT_WIDTH-1:0]  dbit_q, dbit_d;
  logic [CNT_WIDTH-1:0]  fault_q, fault_d;
  logic                  err_vld_q, err_vld_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [2:0]            err_type_q, err_type_d;
  logic                  irq_q, irq_d;

  // Clear wins over the stored value, then the current event is still counted.
  function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cur,
                                                    input logic clr, input logic inc);
    logic [CNT_WIDTH-1:0] base;
    base = clr ? '0 : cur;
    if (inc && (base != CNT_MAX)) base = base + CNT_WIDTH'(1);
    return base;
  endfunction

  assign in_rdy   = ~out_vld_q | out_rdy;
  assign accept   = in_vld & in_rdy;
  assign flags    = {in_ecc_fault, in_dbit_err, in_sbit_err};
  assign err_beat = accept & (|flags);

  always_comb begin
    out_vld_d  = out_vld_q;
    data_d     = data_q;
    bad_d      = bad_q;
    err_vld_d  = err_vld_q;
    err_addr_d = err_addr_q;
    err_type_d = err_type_q;

    if (accept) begin
      out_vld_d = 1'b1;
      data_d    = in_data;
      bad_d     = in_dbit_err | in_ecc_fault;
    end else if (out_rdy) begin
      out_vld_d = 1'b0;
    end

    sbit_d  = cnt_next(sbit_q,  cnt_clr, accept & in_sbit_err);
    dbit_d  = cnt_next(dbit_q,  cnt_clr, accept & in_dbit_err);
    fault_d = cnt_next(fault_q, cnt_clr, accept & in_ecc_fault);

    // A release colliding with a new error re-arms the log on that error.
    if (err_beat && (!err_vld_q || err_clr)) begin
      err_vld_d  = 1'b1;
      err_addr_d = in_addr;
      err_type_d = flags;
    end else if (err_clr) begin
      err_vld_d = 1'b0;
    end

    irq_d = err_vld_d & irq_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      data_q     <= '0;
      bad_q      <= 1'b0;
      sbit_q     <= '0;
      dbit_q     <= '0;
      fault_q    <= '0;
      err_vld_q  <= 1'b0;
      err_addr_q <= '0;
      err_type_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      data_q     <= data_d;
      bad_q      <= bad_d;
      sbit_q     <= sbit_d;
      dbit_q     <= dbit_d;
      fault_q    <= fault_d;
      err_vld_q  <= err_vld_d;
      err_addr_q <= err_addr_d;
      err_type_q <= err_type_d;
      irq_q      <= irq_d;
    end
  end

  assign out_vld   = out_vld_q;
  assign out_data  = data_q;
  assign out_bad   = bad_q;
  assign sbit_cnt  = sbit_q;
  assign dbit_cnt  = dbit_q;
  assign fault_cnt = fault_q;
  assign err_vld   = err_vld_q;
  assign err_addr  = err_addr_q;
  assign err_type  = err_type_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_ecc_148_err_collect.sv
// Scoreboard bench for ecc_148_err_collect: beats are queued when the model
// accepts them and a negedge monitor checks what the DUT presents downstream.
module tb_ecc_148_err_collect;
  localparam int DW = 148;
  localparam int AW = 8;
  localparam int CW = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_vld = 1'b0;
  logic          in_rdy;
  logic [AW-1:0] in_addr = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_sbit_err = 1'b0, in_dbit_err = 1'b0, in_ecc_fault = 1'b0;
  logic          out_vld;
  logic          out_rdy = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_bad;
  logic [CW-1:0] sbit_cnt, dbit_cnt, fault_cnt;
  logic          cnt_clr = 1'b0;
  logic          err_vld;
  logic [AW-1:0] err_addr;
  logic [2:0]    err_type;
  logic          err_clr = 1'b0;
  logic          irq_en = 1'b0;
  logic          irq;

  ecc_148_err_collect #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_addr(in_addr), .in_data(in_data),
    .in_sbit_err(in_sbit_err), .in_dbit_err(in_dbit_err), .in_ecc_fault(in_ecc_fault),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_bad(out_bad),
    .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt), .cnt_clr(cnt_clr),
    .err_vld(err_vld), .err_addr(err_addr), .err_type(err_type), .err_clr(err_clr),
    .irq_en(irq_en), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected downstream beats: {bad, data}
  logic [DW:0] sb[$];

  // Reference state
  bit       m_out_vld;
  int       m_cnt[3];   // 0 sbit, 1 dbit, 2 fault
  bit       m_err_vld;
  int       m_err_addr;
  int       m_err_type;
  bit       m_irq;
  bit       m_pending;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_vld) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        chk("out_data", out_data, sb[0][DW-1:0]);
        chk("out_bad", out_bad, sb[0][DW]);
        if (out_rdy) void'(sb.pop_front());
      end
    end
  end

  function automatic logic [DW-1:0] rand_data();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  function automatic void model_reset();
    m_out_vld = 0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_err_vld = 0; m_err_addr = 0; m_err_type = 0; m_irq = 0; m_pending = 0;
  endfunction

  // One clock cycle; entered and left at posedge+1. f = {fault, dbit, sbit}.
  task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [2:0] f, input logic ordy, input logic cclr,
                      input logic eclr, input logic ien);
    bit rdy, acc;
    in_vld = v; in_addr = a; in_data = d;
    in_sbit_err = f[0]; in_dbit_err = f[1]; in_ecc_fault = f[2];
    out_rdy = ordy; cnt_clr = cclr; err_clr = eclr; irq_en = ien;
    #1;
    rdy = !m_out_vld || ordy;
    chk("in_rdy", in_rdy, rdy);
    acc = v && rdy;
    if (acc) sb.push_back({f[2] | f[1], d});
    @(posedge clk); #1;
    if (acc) m_out_vld = 1; else if (ordy) m_out_vld = 0;
    for (int i = 0; i < 3; i++) begin
      if (cclr) m_cnt[i] = 0;
      if (acc && f[i] && m_cnt[i] < CMAX) m_cnt[i]++;
    end
    if (acc && f != 0 && (!m_err_vld || eclr)) begin
      m_err_vld = 1; m_err_addr = a; m_err_type = f;
    end else if (eclr) begin
      m_err_vld = 0;
    end
    m_irq = m_err_vld && ien;
    m_pending = v && !acc;
    chk("out_vld", out_vld, m_out_vld);
    chk("sbit_cnt", sbit_cnt, m_cnt[0]);
    chk("dbit_cnt", dbit_cnt, m_cnt[1]);
    chk("fault_cnt", fault_cnt, m_cnt[2]);
    chk("err_vld", err_vld, m_err_vld);
    chk("err_addr", err_addr, m_err_addr);
    chk("err_type", err_type, m_err_type);
    chk("irq", irq, m_irq);
  endtask

  task automatic idle(input logic ien);
    step(0, '0, '0, 3'b000, 1, 0, 0, ien);
  endtask

  // Asynchronous reset in mid-cycle; outputs must drop before any clock edge.
  task automatic async_reset();
    #2;
    rst_n = 0;
    in_vld = 0; cnt_clr = 0; err_clr = 0;
    #1;
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_bad", out_bad, 0);
    chk("rst_cnts", {sbit_cnt, dbit_cnt, fault_cnt}, 0);
    chk("rst_err", {err_vld, err_addr, err_type}, 0);
    chk("rst_irq", irq, 0);
    chk("rst_in_rdy", in_rdy, 1);
    model_reset();
    sb.delete();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [2:0]    f;
    logic          v, ordy, cclr, eclr, ien;
    int            n;

    model_reset();
    #2;
    chk("init_in_rdy", in_rdy, 1);
    chk("init_out_vld", out_vld, 0);
    chk("init_irq", irq, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;

    // Clean stream
    for (int i = 0; i < 10; i++) step(1, AW'(i), rand_data(), 3'b000, 1, 0, 0, 0);
    idle(0);
    chk("clean_err_vld", err_vld, 0);
    chk("clean_sbit", sbit_cnt, 0);

    // Backpressure: 3 held cycles mid-stream, every beat retried until taken
    n = 0;
    for (int i = 0; i < 8; i++) begin
      d = rand_data();
      do begin
        ordy = !(n >= 3 && n < 6);
        step(1, AW'(8'h20 + i), d, 3'b000, ordy, 0, 0, 0);
        if (!ordy) chk("bp_in_rdy_low", in_rdy, 0);
        n++;
      end while (m_pending && n < 50);
    end
    idle(0); idle(0);
    chk("bp_drained", sb.size(), 0);

    // First-error log
    step(0, '0, '0, 3'b000, 1, 1, 1, 1);
    step(1, 8'h12, rand_data(), 3'b001, 1, 0, 0, 1);
    chk("log_irq_first", irq, 1);
    step(1, 8'h34, rand_data(), 3'b010, 1, 0, 0, 1);
    idle(1);
    chk("log_addr", err_addr, 8'h12);
    chk("log_type", err_type, 3'b001);
    chk("log_sbit", sbit_cnt, 1);
    chk("log_dbit", dbit_cnt, 1);

    // Clear collisions
    step(1, 8'h56, rand_data(), 3'b100, 1, 0, 1, 1);
    chk("coll_vld", err_vld, 1);
    chk("coll_addr", err_addr, 8'h56);
    chk("coll_type", err_type, 3'b100);
    step(1, 8'h57, rand_data(), 3'b001, 1, 1, 0, 1);
    chk("coll_sbit", sbit_cnt, 1);

    // irq_en transitions
    idle(0);
    chk("irq_en_off", irq, 0);
    idle(1);
    chk("irq_en_on", irq, 1);

    // Saturation
    for (int i = 0; i < 20; i++) step(1, AW'(i), rand_data(), 3'b001, 1, 0, 0, 0);
    idle(0);
    chk("sat_sbit", sbit_cnt, CMAX);
    step(0, '0, '0, 3'b000, 1, 1, 0, 0);
    chk("sat_clr", sbit_cnt, 0);

    // Reset with a held beat and a live log
    step(1, 8'h77, rand_data(), 3'b010, 0, 0, 0, 1);
    chk("pre_rst_held", out_vld, 1);
    async_reset();
    step(1, 8'h01, rand_data(), 3'b000, 1, 0, 0, 0);
    chk("post_rst_lat", out_vld, 1);
    idle(0);

    // Randomized traffic honouring the upstream hold rule
    ien = 0; v = 0; a = '0; d = '0; f = '0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) async_reset();
      if (!m_pending) begin
        v = ($urandom_range(0, 3) != 0);
        a = AW'($urandom);
        d = rand_data();
        f = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      end
      ordy = ($urandom_range(0, 3) != 0);
      cclr = ($urandom_range(0, 40) == 0);
      eclr = ($urandom_range(0, 12) == 0);
      if ($urandom_range(0, 30) == 0) ien = ~ien;
      step(v, a, d, f, ordy, cclr, eclr, ien);
    end

    for (int i = 0; i < 4; i++) idle(0);
    chk("final_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
